mult_seq_32: RTL and testbench

//  Iterative unsigned 32x32->64 shift-add multiplier built around one CLA_32 instance.
//  Per cycle it drives the adder operands and registers the sum and carry-out.

---
 rtl/mult_seq_32.sv | 165 ++++++++++++++++
 tb/tb_mult_seq_32.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_32.sv
// Iterative unsigned 32x32->64 shift-add multiplier.
// One 32-bit carry-lookahead adder is reused every iteration; valid/ready on
// both the operand and the result side, one operation in flight at a time.

// 4-bit carry-lookahead group: local sum plus group generate/propagate.
module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       g_o,
  output logic       p_o
);
  logic [3:0] g, p, c;

  // Bit generate/propagate, lookahead carries and the group terms.
  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    s_o  = p ^ c;
    g_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    p_o  = &p;
  end
endmodule

// 32-bit adder built from eight lookahead groups.
module CLA_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_in_i,
  output logic [31:0] s_o,
  output logic        c_out_o,
  output logic        ovf_o
);
  localparam int NGRP = 8;

  logic [NGRP-1:0] grp_g, grp_p;
  logic [NGRP:0]   grp_c;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      cla4 u_grp (
        .a_i (a_i[gi*4 +: 4]),
        .b_i (b_i[gi*4 +: 4]),
        .c_i (grp_c[gi]),
        .s_o (s_o[gi*4 +: 4]),
        .g_o (grp_g[gi]),
        .p_o (grp_p[gi])
      );
    end
  endgenerate

  // Carry between groups from the group generate/propagate terms.
  always_comb begin
    grp_c[0] = c_in_i;
    for (int i = 0; i < NGRP; i++)
      grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
  end

  assign c_out_o = grp_c[NGRP];
  // Two's-complement overflow: like-signed operands with a differently signed sum.
  assign ovf_o   = (a_i[31] == b_i[31]) && (s_o[31] != a_i[31]);
endmodule

// Sequential multiplier. WIDTH must stay 32 (adder width) and 2**CNT_W == WIDTH.
module mult_seq_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               hi_nz
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_s;
  logic               add_cout;
  logic               cla_ovf_unused;

  // Partial-product add: accumulate the multiplicand when the current multiplier bit is set.
  assign add_b = lo_q[0] ? mcand_q : '0;

  CLA_32 u_cla (
    .a_i     (hi_q),
    .b_i     (add_b),
    .c_in_i  (1'b0),
    .s_o     (add_s),
    .c_out_o (add_cout),
    .ovf_o   (cla_ovf_unused)
  );

  // State and datapath registers; reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next state: accept in IDLE, one shift-add per RUN cycle, hold result in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // {carry, sum, lo} shifted right by one; the carry lands in the top bit.
        hi_d  = {add_cout, add_s[WIDTH-1:1]};
        lo_d  = {add_s[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1))
          state_d = DONE;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = {hi_q, lo_q};
  assign hi_nz     = |hi_q;
endmodule

// File: tb/tb_mult_seq_32.sv
// Bench for mult_seq_32: stimulus pushes a*b into a scoreboard queue, a monitor
// pops and compares whenever a product is presented, and drives out_ready.
module tb_mult_seq_32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] product;
  logic        hi_nz;

  mult_seq_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .hi_nz     (hi_nz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [63:0] p;
    logic        hnz;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Monitor controls
  int          hold_n   = 0;
  bit          rnd      = 1'b0;
  bit          have_cur = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: compare on first presentation, check hold stability, decide out_ready.
  initial begin : monitor
    logic [63:0] cur_p;
    logic        cur_h;
    int          hold_left;
    bit          hs_pend;
    exp_t        e;
    cur_p = '0; cur_h = 1'b0; hold_left = 0; hs_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_cur  = 1'b0;
        hs_pend   = 1'b0;
        hold_left = 0;
        out_ready = 1'b0;
      end else begin
        if (hs_pend) begin
          chk("post_hs_out_valid", {63'b0, out_valid}, 64'd0);
          chk("post_hs_in_ready", {63'b0, in_ready}, 64'd1);
          hs_pend = 1'b0;
        end
        if (out_valid) begin
          if (!have_cur) begin
            if (exp_q.size() == 0) begin
              chk("spurious_out_valid", {63'b0, out_valid}, 64'd0);
            end else begin
              e = exp_q.pop_front();
              chk("product", product, e.p);
              chk("hi_nz", {63'b0, hi_nz}, {63'b0, e.hnz});
              chk("latency", 64'(cyc - e.acc - 1), 64'd32);
            end
            have_cur  = 1'b1;
            cur_p     = product;
            cur_h     = hi_nz;
            hold_left = hold_n;
            hold_n    = 0;
          end else begin
            chk("held_product", product, cur_p);
            chk("held_hi_nz", {63'b0, hi_nz}, {63'b0, cur_h});
            chk("held_in_ready", {63'b0, in_ready}, 64'd0);
          end
          if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
          end else if (rnd) begin
            out_ready = ($urandom_range(0, 3) != 0);
          end else begin
            out_ready = 1'b1;
          end
          if (out_ready) begin
            hs_pend  = 1'b1;
            have_cur = 1'b0;
          end
        end else begin
          out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
    end
  end

  // Present one operand pair; with churn, a/b wander until accepted.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input bit churn,
                      input bit hold, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    while (!in_ready && waited < 400) begin
      @(negedge clk);
      waited++;
      if (churn) begin
        a = $urandom;
        b = $urandom;
      end
    end
    if (!in_ready) begin
      chk("accept_timeout", {63'b0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    a = x;
    b = y;
    e.p   = {32'b0, x} * {32'b0, y};
    e.hnz = (e.p[63:32] != 32'd0);
    e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (hold) begin
      a = $urandom;
      b = $urandom;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || have_cur) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || have_cur)
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    int w;
    int ov_cnt;
    logic [31:0] x, y;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_hi_nz", {63'b0, hi_nz}, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Basic small product, accepted on the first edge
    send(32'd3, 32'd5, 1'b0, 1'b0, w);
    chk("first_accept_wait", 64'(w), 64'd0);
    wait_idle();

    // All-ones: carry-out reaches bit 63
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, w);
    wait_idle();

    // Consumer stalls 10 cycles; result must hold
    hold_n = 10;
    send(32'h8000_0000, 32'd2, 1'b0, 1'b0, w);
    wait_idle();

    // in_valid held with changing operands during RUN
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, w);
    send(32'hDEAD_BEEF, 32'h0000_0100, 1'b1, 1'b0, w);
    wait_idle();

    // Zero operands still produce a clean zero
    send(32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, w);
    send(32'hCAFE_F00D, 32'd0, 1'b0, 1'b0, w);
    wait_idle();

    // Reset in the middle of RUN aborts the operation
    send(32'd9876, 32'd12345, 1'b0, 1'b0, w);
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {63'b0, in_ready}, 64'd1);
    chk("abort_out_valid", {63'b0, out_valid}, 64'd0);
    chk("abort_product", product, 64'd0);
    chk("abort_hi_nz", {63'b0, hi_nz}, 64'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    ov_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("no_out_valid_after_abort", 64'(ov_cnt), 64'd0);
    send(32'd7, 32'd6, 1'b0, 1'b0, w);
    wait_idle();

    // Random traffic with random consumer stalls
    rnd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       x = 32'd0;
        1:       x = 32'd1;
        2:       x = 32'hFFFF_FFFF;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'd1;
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      send(x, y, 1'b0, 1'b0, w);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_idle();
    rnd = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
